// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall, flush, sticky halt/err and load-use detection.
// Optional operand forwarding is enabled by defining ID_EX_FWD_EN.
module id_ex_reg #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [4:0]       id_aluOp,
    input  logic [1:0]       id_last2Bits,
    input  logic [WIDTH-1:0] id_rsData,
    input  logic [WIDTH-1:0] id_rtData,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_aluSrc,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_wrReg,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             id_memWrite,
`ifdef ID_EX_FWD_EN
    input  logic             mem_regWrite,
    input  logic [RA_W-1:0]  mem_wrReg,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_regWrite,
    input  logic [RA_W-1:0]  wb_wrReg,
    input  logic [WIDTH-1:0] wb_result,
`endif
    output logic             ex_valid,
    output logic [4:0]       ex_aluOp,
    output logic [1:0]       ex_last2Bits,
    output logic [WIDTH-1:0] ex_A,
    output logic [WIDTH-1:0] ex_B,
    output logic [WIDTH-1:0] ex_stData,
    output logic [RA_W-1:0]  ex_wrReg,
    output logic             ex_regWrite,
    output logic             ex_memRead,
    output logic             ex_memWrite,
    output logic             ld_use_stall,
    output logic             ex_halt,
    output logic             err
);

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_BAD0 = 5'b00010;
    localparam logic [4:0] OP_BAD1 = 5'b00011;

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] reg_st;
    logic             bubble;
    logic             load;

    // Decide between inserting a bubble, capturing ID, or holding
    always_comb begin
        bubble = 1'b0;
        load   = 1'b0;
        if (rst || flush || ex_halt) begin
            bubble = 1'b1;
        end else if (!stall) begin
            bubble = !id_valid;
            load   = id_valid;
        end
    end

    // EX-side instruction registers
    always_ff @(posedge clk) begin
        if (bubble) begin
            ex_valid     <= 1'b0;
            ex_aluOp     <= OP_NOP;
            ex_last2Bits <= '0;
            ex_wrReg     <= '0;
            ex_regWrite  <= 1'b0;
            ex_memRead   <= 1'b0;
            ex_memWrite  <= 1'b0;
            reg_a        <= '0;
            reg_b        <= '0;
            reg_st       <= '0;
        end else if (load) begin
            ex_valid     <= 1'b1;
            ex_aluOp     <= id_aluOp;
            ex_last2Bits <= id_last2Bits;
            ex_wrReg     <= id_wrReg;
            ex_regWrite  <= id_regWrite;
            ex_memRead   <= id_memRead;
            ex_memWrite  <= id_memWrite;
            reg_a        <= id_rsData;
            reg_b        <= id_aluSrc ? id_imm : id_rtData;
            reg_st       <= id_rtData;
        end
    end

    // Sticky halt/err, set only when the offending op actually enters EX
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_halt <= 1'b0;
            err     <= 1'b0;
        end else if (load) begin
            if (id_aluOp == OP_HALT)
                ex_halt <= 1'b1;
            if (id_aluOp == OP_BAD0 || id_aluOp == OP_BAD1)
                err <= 1'b1;
        end
    end

    // Load-use hazard: rt only matters when used as B operand or store data
    always_comb begin
        ld_use_stall = ex_valid & ex_memRead & id_valid & !ex_halt &
                       ((ex_wrReg == id_rs) |
                        ((ex_wrReg == id_rt) & (!id_aluSrc | id_memWrite)));
    end

`ifdef ID_EX_FWD_EN
    logic [RA_W-1:0] reg_rs;
    logic [RA_W-1:0] reg_rt;
    logic            reg_aluSrc;

    function automatic logic [WIDTH-1:0] fwd(
        input logic [RA_W-1:0]  r,
        input logic [WIDTH-1:0] d
    );
        if (mem_regWrite && mem_wrReg == r)
            return mem_result;
        else if (wb_regWrite && wb_wrReg == r)
            return wb_result;
        else
            return d;
    endfunction

    // Source register numbers kept for forwarding comparisons
    always_ff @(posedge clk) begin
        if (bubble) begin
            reg_rs     <= '0;
            reg_rt     <= '0;
            reg_aluSrc <= 1'b0;
        end else if (load) begin
            reg_rs     <= id_rs;
            reg_rt     <= id_rt;
            reg_aluSrc <= id_aluSrc;
        end
    end

    // Forwarded operands, EX/MEM result wins over MEM/WB
    always_comb begin
        ex_A      = fwd(reg_rs, reg_a);
        ex_B      = reg_aluSrc ? reg_b : fwd(reg_rt, reg_b);
        ex_stData = fwd(reg_rt, reg_st);
    end
`else
    // Registered operands straight to EX
    always_comb begin
        ex_A      = reg_a;
        ex_B      = reg_b;
        ex_stData = reg_st;
    end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed self-checking bench for id_ex_reg.
// Forwarding checks are compiled in when ID_EX_FWD_EN is defined.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [4:0]  id_aluOp;
    logic [1:0]  id_last2Bits;
    logic [15:0] id_rsData, id_rtData, id_imm;
    logic        id_aluSrc;
    logic [2:0]  id_rs, id_rt, id_wrReg;
    logic        id_regWrite, id_memRead, id_memWrite;
`ifdef ID_EX_FWD_EN
    logic        mem_regWrite, wb_regWrite;
    logic [2:0]  mem_wrReg, wb_wrReg;
    logic [15:0] mem_result, wb_result;
`endif
    logic        ex_valid;
    logic [4:0]  ex_aluOp;
    logic [1:0]  ex_last2Bits;
    logic [15:0] ex_A, ex_B, ex_stData;
    logic [2:0]  ex_wrReg;
    logic        ex_regWrite, ex_memRead, ex_memWrite;
    logic        ld_use_stall, ex_halt, err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_aluOp(id_aluOp),
        .id_last2Bits(id_last2Bits), .id_rsData(id_rsData),
        .id_rtData(id_rtData), .id_imm(id_imm),
        .id_aluSrc(id_aluSrc), .id_rs(id_rs), .id_rt(id_rt),
        .id_wrReg(id_wrReg), .id_regWrite(id_regWrite),
        .id_memRead(id_memRead), .id_memWrite(id_memWrite),
`ifdef ID_EX_FWD_EN
        .mem_regWrite(mem_regWrite), .mem_wrReg(mem_wrReg),
        .mem_result(mem_result), .wb_regWrite(wb_regWrite),
        .wb_wrReg(wb_wrReg), .wb_result(wb_result),
`endif
        .ex_valid(ex_valid), .ex_aluOp(ex_aluOp),
        .ex_last2Bits(ex_last2Bits), .ex_A(ex_A), .ex_B(ex_B),
        .ex_stData(ex_stData), .ex_wrReg(ex_wrReg),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .ld_use_stall(ld_use_stall),
        .ex_halt(ex_halt), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] op,
                          input logic [15:0] rsd, input logic [15:0] rtd,
                          input logic [15:0] imm, input logic src,
                          input logic [2:0] rs, input logic [2:0] rt,
                          input logic [2:0] wr, input logic rw,
                          input logic mr, input logic mw);
        id_valid = v; id_aluOp = op; id_last2Bits = 2'b00;
        id_rsData = rsd; id_rtData = rtd; id_imm = imm;
        id_aluSrc = src; id_rs = rs; id_rt = rt; id_wrReg = wr;
        id_regWrite = rw; id_memRead = mr; id_memWrite = mw;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_id(1'b0, 5'd0, 16'h0, 16'h0, 16'h0, 1'b0,
               3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
`ifdef ID_EX_FWD_EN
        mem_regWrite = 1'b0; mem_wrReg = 3'd0; mem_result = 16'h0;
        wb_regWrite = 1'b0; wb_wrReg = 3'd0; wb_result = 16'h0;
`endif
        tick(); tick();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_aluOp", 32'(ex_aluOp), 32'd1);
        chk("rst_halt", 32'(ex_halt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_A", 32'(ex_A), 32'd0);
        chk("rst_B", 32'(ex_B), 32'd0);
        chk("rst_st", 32'(ex_stData), 32'd0);
        chk("rst_wr", 32'(ex_wrReg), 32'd0);

        // ADDI r2 = r1 + 3
        rst = 1'b0;
        set_id(1'b1, 5'b01000, 16'h0005, 16'h0007, 16'h0003, 1'b1,
               3'd1, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        chk("addi_A", 32'(ex_A), 32'h5);
        chk("addi_B", 32'(ex_B), 32'h3);
        chk("addi_st", 32'(ex_stData), 32'h7);
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_op", 32'(ex_aluOp), 32'h08);
        chk("addi_wr", 32'(ex_wrReg), 32'd2);
        chk("addi_rw", 32'(ex_regWrite), 32'd1);

        // stall holds everything
        stall = 1'b1;
        set_id(1'b1, 5'b01100, 16'h0009, 16'h0004, 16'h0001, 1'b0,
               3'd3, 3'd4, 3'd5, 1'b0, 1'b1, 1'b0);
        tick();
        chk("stall_A", 32'(ex_A), 32'h5);
        chk("stall_B", 32'(ex_B), 32'h3);
        chk("stall_op", 32'(ex_aluOp), 32'h08);
        chk("stall_wr", 32'(ex_wrReg), 32'd2);
        chk("stall_mr", 32'(ex_memRead), 32'd0);

        // flush beats stall
        flush = 1'b1;
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_op", 32'(ex_aluOp), 32'd1);
        chk("flush_A", 32'(ex_A), 32'd0);
        stall = 1'b0; flush = 1'b0;

        // R-type with aluSrc=0 takes B from rtData
        set_id(1'b1, 5'b11011, 16'h1234, 16'h00F0, 16'hFFFF, 1'b0,
               3'd1, 3'd2, 3'd6, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rtype_B", 32'(ex_B), 32'h00F0);
        chk("rtype_A", 32'(ex_A), 32'h1234);

        // id_valid=0 loads a bubble
        id_valid = 1'b0;
        tick();
        chk("novalid_valid", 32'(ex_valid), 32'd0);
        chk("novalid_rw", 32'(ex_regWrite), 32'd0);

        // LD r3 into EX, then load-use checks
        set_id(1'b1, 5'b10001, 16'h0010, 16'h0000, 16'h0004, 1'b1,
               3'd1, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ld_mr", 32'(ex_memRead), 32'd1);
        chk("ld_B", 32'(ex_B), 32'h4);
        set_id(1'b1, 5'b11011, 16'h0, 16'h0, 16'h0, 1'b0,
               3'd3, 3'd4, 3'd5, 1'b1, 1'b0, 1'b0);
        #1 chk("lu_rs", 32'(ld_use_stall), 32'd1);
        id_rs = 3'd2;
        #1 chk("lu_none", 32'(ld_use_stall), 32'd0);
        id_rt = 3'd3;
        #1 chk("lu_rt", 32'(ld_use_stall), 32'd1);
        id_aluSrc = 1'b1;
        #1 chk("lu_rt_imm", 32'(ld_use_stall), 32'd0);
        id_memWrite = 1'b1;
        #1 chk("lu_rt_store", 32'(ld_use_stall), 32'd1);
        id_valid = 1'b0;
        #1 chk("lu_idinv", 32'(ld_use_stall), 32'd0);

        // illegal op sets sticky err
        set_id(1'b1, 5'b00010, 16'h0, 16'h0, 16'h0, 1'b0,
               3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("err_set", 32'(err), 32'd1);
        set_id(1'b1, 5'b11011, 16'h0002, 16'h0003, 16'h0, 1'b0,
               3'd1, 3'd2, 3'd4, 1'b1, 1'b0, 1'b0);
        tick();
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_nextvalid", 32'(ex_valid), 32'd1);

        // HALT reaches EX
        id_aluOp = 5'b00000;
        tick();
        chk("halt_set", 32'(ex_halt), 32'd1);
        chk("halt_valid", 32'(ex_valid), 32'd1);
        chk("halt_op", 32'(ex_aluOp), 32'd0);
        id_aluOp = 5'b11011;
        tick();
        chk("halted_valid", 32'(ex_valid), 32'd0);
        chk("halted_op", 32'(ex_aluOp), 32'd1);
        tick();
        chk("halt_sticky", 32'(ex_halt), 32'd1);

        rst = 1'b1;
        tick();
        chk("rst2_halt", 32'(ex_halt), 32'd0);
        chk("rst2_err", 32'(err), 32'd0);
        rst = 1'b0;

`ifdef ID_EX_FWD_EN
        set_id(1'b1, 5'b11011, 16'h1111, 16'h2222, 16'h0, 1'b0,
               3'd2, 3'd5, 3'd6, 1'b1, 1'b0, 1'b0);
        tick();
        mem_regWrite = 1'b1; mem_wrReg = 3'd2; mem_result = 16'hAAAA;
        wb_regWrite = 1'b1; wb_wrReg = 3'd2; wb_result = 16'hBBBB;
        #1 chk("fwd_mem", 32'(ex_A), 32'hAAAA);
        chk("fwd_B_none", 32'(ex_B), 32'h2222);
        mem_regWrite = 1'b0;
        #1 chk("fwd_wb", 32'(ex_A), 32'hBBBB);
        wb_wrReg = 3'd5;
        #1 chk("fwd_B_wb", 32'(ex_B), 32'hBBBB);
        chk("fwd_st_wb", 32'(ex_stData), 32'hBBBB);
        chk("fwd_A_reg", 32'(ex_A), 32'h1111);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
